// File: rtl/branch_pkg.sv
// Shared types for the branch-resolution unit.
// Address type, resolve FSM states and flush counter width.
package branch_pkg;

  localparam int ADDR_W      = 32;
  localparam int FLUSH_CNT_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } resolve_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Sticks at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: bump unless already saturated.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {WIDTH{1'b1}}))
      value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: detects next-PC mispredicts,
// reports them to the frontend and squashes wrong-path work.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_ctrl,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_pred_pc,
  input  logic [31:0] ex_actual_pc,
  output logic        miss,
  output logic [31:0] prev_pc,
  output logic [31:0] prev_instr,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] miss_count
);

  resolve_state_t         state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   miss_q, miss_d;
  logic                   flush_q, flush_d;
  addr_t                  prev_pc_q, prev_pc_d;
  logic [31:0]            prev_instr_q, prev_instr_d;
  addr_t                  redirect_q, redirect_d;

  logic accept;
  logic mis;
  logic br_inc;

  assign accept = ex_valid && (state_q == IDLE);
  assign mis    = accept && (ex_pred_pc != ex_actual_pc);
  assign br_inc = accept && ex_is_ctrl;

  // FSM next-state: a mismatch arms the flush window, which
  // counts down and returns to IDLE after its last cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_d       = 1'b0;
    flush_d      = 1'b0;
    prev_pc_d    = prev_pc_q;
    prev_instr_d = prev_instr_q;
    redirect_d   = redirect_q;
    unique case (state_q)
      IDLE: begin
        if (mis) begin
          state_d      = FLUSH;
          cnt_d        = FLUSH_CNT_W'(FLUSH_DEPTH);
          miss_d       = 1'b1;
          flush_d      = 1'b1;
          prev_pc_d    = ex_pc;
          prev_instr_d = ex_instr;
          redirect_d   = ex_actual_pc;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == FLUSH_CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and report registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_q       <= 1'b0;
      flush_q      <= 1'b0;
      prev_pc_q    <= '0;
      prev_instr_q <= '0;
      redirect_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_q       <= miss_d;
      flush_q      <= flush_d;
      prev_pc_q    <= prev_pc_d;
      prev_instr_q <= prev_instr_d;
      redirect_q   <= redirect_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_inc),
    .value (branch_count)
  );

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mis),
    .value (miss_count)
  );

  assign miss        = miss_q;
  assign flush       = flush_q;
  assign prev_pc     = prev_pc_q;
  assign prev_instr  = prev_instr_q;
  assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with FLUSH_DEPTH=2,
// plus a narrow sat_counter instance for saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_is_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_pred_pc;
  logic [31:0] ex_actual_pc;
  logic        miss;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  logic       s_reset;
  logic       s_inc;
  logic [2:0] s_value;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve #(.FLUSH_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_is_ctrl   (ex_is_ctrl),
    .ex_pc        (ex_pc),
    .ex_instr     (ex_instr),
    .ex_pred_pc   (ex_pred_pc),
    .ex_actual_pc (ex_actual_pc),
    .miss         (miss),
    .prev_pc      (prev_pc),
    .prev_instr   (prev_instr),
    .redirect_pc  (redirect_pc),
    .flush        (flush),
    .branch_count (branch_count),
    .miss_count   (miss_count)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .reset (s_reset),
    .inc   (s_inc),
    .value (s_value)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] pred, input logic [31:0] act);
    ex_valid     = v;
    ex_is_ctrl   = c;
    ex_pc        = pc;
    ex_instr     = ins;
    ex_pred_pc   = pred;
    ex_actual_pc = act;
  endtask

  initial begin
    int miss_seen;
    reset   = 1'b1;
    s_reset = 1'b1;
    s_inc   = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
    step();
    check("rst_miss", {31'b0, miss}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_prev_pc", prev_pc, 32'd0);
    check("rst_prev_instr", prev_instr, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_bcnt", branch_count, 32'd0);
    check("rst_mcnt", miss_count, 32'd0);
    reset   = 1'b0;
    s_reset = 1'b0;

    // correct prediction
    drive(1'b1, 1'b1, 32'h0040_0010, 32'h0000_0063,
          32'h0040_0014, 32'h0040_0014);
    step();
    check("ok_miss", {31'b0, miss}, 32'd0);
    check("ok_flush", {31'b0, flush}, 32'd0);
    check("ok_bcnt", branch_count, 32'd1);

    // mispredict at edge t
    drive(1'b1, 1'b1, 32'h0040_0020, 32'h1000_0004,
          32'h0040_0024, 32'h0040_0034);
    step();
    check("mp_miss", {31'b0, miss}, 32'd1);
    check("mp_redirect", redirect_pc, 32'h0040_0034);
    check("mp_prev_pc", prev_pc, 32'h0040_0020);
    check("mp_prev_instr", prev_instr, 32'h1000_0004);
    check("mp_flush1", {31'b0, flush}, 32'd1);
    check("mp_mcnt", miss_count, 32'd1);
    check("mp_bcnt", branch_count, 32'd2);

    // wrong-path mismatches during t+1 and t+2
    drive(1'b1, 1'b1, 32'h0050_0000, 32'hdead_beef,
          32'h0000_0001, 32'h0000_0002);
    step();
    check("wp_miss2", {31'b0, miss}, 32'd0);
    check("wp_flush2", {31'b0, flush}, 32'd1);
    check("wp_mcnt2", miss_count, 32'd1);
    step();
    check("wp_miss3", {31'b0, miss}, 32'd0);
    check("wp_flush3", {31'b0, flush}, 32'd0);
    check("wp_mcnt3", miss_count, 32'd1);
    check("wp_bcnt3", branch_count, 32'd2);
    check("wp_prev_pc", prev_pc, 32'h0040_0020);

    // non-control mismatch at t+3
    drive(1'b1, 1'b0, 32'h0040_0040, 32'h0000_0013,
          32'h0040_0044, 32'h0040_0100);
    step();
    check("nc_miss", {31'b0, miss}, 32'd1);
    check("nc_prev_pc", prev_pc, 32'h0040_0040);
    check("nc_redirect", redirect_pc, 32'h0040_0100);
    check("nc_mcnt", miss_count, 32'd2);
    check("nc_bcnt", branch_count, 32'd2);

    // hold: 2 ignored flush cycles then 20 correct predictions
    drive(1'b1, 1'b1, 32'h0040_0100, 32'h0000_0063,
          32'h0040_0104, 32'h0040_0104);
    miss_seen = 0;
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (miss) miss_seen++;
    end
    check("hold_miss", miss_seen, 32'd0);
    check("hold_prev_pc", prev_pc, 32'h0040_0040);
    check("hold_prev_instr", prev_instr, 32'h0000_0013);
    check("hold_bcnt", branch_count, 32'd22);
    check("hold_mcnt", miss_count, 32'd2);

    // reset in the middle of FLUSH
    drive(1'b1, 1'b1, 32'h0040_0200, 32'h1000_0008,
          32'h0040_0204, 32'h0040_0300);
    step();
    check("rf_miss", {31'b0, miss}, 32'd1);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rf_miss0", {31'b0, miss}, 32'd0);
    check("rf_flush0", {31'b0, flush}, 32'd0);
    check("rf_prev_pc", prev_pc, 32'd0);
    check("rf_redirect", redirect_pc, 32'd0);
    check("rf_mcnt", miss_count, 32'd0);
    drive(1'b1, 1'b1, 32'h0040_0010, 32'h0000_0063,
          32'h0040_0014, 32'h0040_0014);
    step();
    check("rf_accept", branch_count, 32'd1);
    check("rf_flush1", {31'b0, flush}, 32'd0);
    drive(1'b0, 1'b0, '0, '0, '0, '0);

    // saturation on a 3-bit counter: 6, then 7, then stuck
    s_inc = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("sat_6", {29'b0, s_value}, 32'd6);
    step();
    check("sat_7", {29'b0, s_value}, 32'd7);
    step();
    step();
    check("sat_hold", {29'b0, s_value}, 32'd7);
    s_inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
